// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier for signed or unsigned W-bit operands.
// One partial product is accumulated per cycle; the sign is applied when the result is published.
module seq_multiplier #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic             Signed,
    input  logic [W-1:0]     din0,
    input  logic [W-1:0]     din1,
    output logic [2*W-1:0]   dout,
    output logic             Busy,
    output logic             Done
);

    localparam int CNT_W = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [2*W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic [2*W-1:0]   dout_q, dout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Magnitude of a W-bit operand; -2^(W-1) maps to 2^(W-1) as an unsigned W-bit value.
    function automatic logic [W-1:0] mag_f(input logic [W-1:0] x, input logic is_signed);
        if (is_signed && x[W-1])
            return ~x + W'(1);
        return x;
    endfunction

    function automatic logic [2*W-1:0] sign_f(input logic [2*W-1:0] m, input logic neg);
        logic signed [2*W-1:0] sm;
        sm = signed'(m);
        if (neg)
            return unsigned'(-sm);
        return m;
    endfunction

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        dout_d   = dout_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                // The DONE cycle publishes the signed result while it can already accept the next operands.
                if (state_q == DONE) begin
                    dout_d = sign_f(acc_q, neg_q);
                    done_d = 1'b1;
                end
                if (Start) begin
                    acc_d    = '0;
                    mcand_d  = {{W{1'b0}}, mag_f(din0, Signed)};
                    mplier_d = mag_f(din1, Signed);
                    neg_d    = Signed & (din0[W-1] ^ din1[W-1]);
                    cnt_d    = CNT_W'(W);
                    state_d  = CALC;
                    busy_d   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                busy_d = 1'b1;
                if (mplier_q[0])
                    acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            dout_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            dout_q   <= dout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign dout = dout_q;
    assign Busy = busy_q;
    assign Done = done_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: W=4 and W=8 instances checked against an integer-arithmetic model.
module tb_seq_multiplier;

    localparam int W  = 4;
    localparam int W8 = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           Start = 1'b0, Signed = 1'b0;
    logic [W-1:0]   din0 = '0, din1 = '0;
    logic [2*W-1:0] dout;
    logic           Busy, Done;

    logic            Start8 = 1'b0, Signed8 = 1'b0;
    logic [W8-1:0]   a8 = '0, b8 = '0;
    logic [2*W8-1:0] dout8;
    logic            Busy8, Done8;

    seq_multiplier #(.W(W)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .Start(Start), .Signed(Signed),
        .din0(din0), .din1(din1), .dout(dout), .Busy(Busy), .Done(Done)
    );

    seq_multiplier #(.W(W8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .Start(Start8), .Signed(Signed8),
        .din0(a8), .din1(b8), .dout(dout8), .Busy(Busy8), .Done(Done8)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] val;
        int          at_edge;
    } exp_t;

    exp_t        q4[$], q8[$];
    int          last4 = -1000, last8 = -1000;
    logic [63:0] hold4 = '0, hold8 = '0;

    // Reference product: interpret operands as integers and keep the low 2w bits.
    function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                            input logic s, input int w);
        longint sa, sb, p;
        logic [63:0] mask;
        sa = longint'(a);
        sb = longint'(b);
        if (s && a[w-1]) sa = sa - (longint'(1) << w);
        if (s && b[w-1]) sb = sb - (longint'(1) << w);
        p = sa * sb;
        mask = (64'(1) << (2 * w)) - 64'(1);
        return 64'(p) & mask;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, req);
        end
    endtask

    // A Start is taken at edge e only once the previous accepted operation has left CALC.
    task automatic drive4(input logic st, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        Start = st; din0 = a; din1 = b; Signed = s;
        if (st && (cyc + 1 >= last4 + W + 1)) begin
            e.val = ref_mul(64'(a), 64'(b), s, W);
            e.at_edge = cyc + 1;
            q4.push_back(e);
            last4 = cyc + 1;
        end
        @(posedge clk); #1;
    endtask

    task automatic drive8(input logic st, input logic [W8-1:0] a, input logic [W8-1:0] b, input logic s);
        exp_t e;
        Start8 = st; a8 = a; b8 = b; Signed8 = s;
        if (st && (cyc + 1 >= last8 + W8 + 1)) begin
            e.val = ref_mul(64'(a), 64'(b), s, W8);
            e.at_edge = cyc + 1;
            q8.push_back(e);
            last8 = cyc + 1;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle4(input int n);
        for (int i = 0; i < n; i++)
            drive4(1'b0, W'($urandom), W'($urandom), 1'($urandom));
    endtask

    task automatic do_reset();
        Start = 1'b0; Start8 = 1'b0;
        rst_n = 1'b0;
        q4.delete(); q8.delete();
        last4 = -1000; last8 = -1000;
        hold4 = '0; hold8 = '0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
    endtask

    exp_t e4m, e8m;
    logic exp_done4, exp_busy4, exp_done8, exp_busy8;

    always @(negedge clk) begin
        exp_busy4 = (cyc >= last4) && (cyc <= last4 + W - 1);
        exp_done4 = (q4.size() > 0) && (q4[0].at_edge + W + 1 == cyc);
        chk("busy4", 64'(Busy), 64'(exp_busy4));
        chk("done4", 64'(Done), 64'(exp_done4));
        if (exp_done4) begin
            e4m = q4.pop_front();
            hold4 = e4m.val;
        end
        chk("dout4", 64'(dout), hold4);
    end

    always @(negedge clk) begin
        exp_busy8 = (cyc >= last8) && (cyc <= last8 + W8 - 1);
        exp_done8 = (q8.size() > 0) && (q8[0].at_edge + W8 + 1 == cyc);
        chk("busy8", 64'(Busy8), 64'(exp_busy8));
        chk("done8", 64'(Done8), 64'(exp_done8));
        if (exp_done8) begin
            e8m = q8.pop_front();
            hold8 = e8m.val;
        end
        chk("dout8", 64'(dout8), hold8);
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;

        // 15*15 unsigned
        drive4(1'b1, 4'd15, 4'd15, 1'b0);
        idle4(6);
        // signed corner cases: -8*7 and -8*-8
        drive4(1'b1, 4'h8, 4'h7, 1'b1);
        idle4(6);
        drive4(1'b1, 4'h8, 4'h8, 1'b1);
        idle4(6);
        // Start pulsed while busy must be ignored
        drive4(1'b1, 4'd3, 4'd5, 1'b0);
        drive4(1'b0, 4'd0, 4'd0, 1'b0);
        drive4(1'b1, 4'd9, 4'd9, 1'b0);
        idle4(6);
        // Start held high: back-to-back issue from DONE
        drive4(1'b1, 4'd2, 4'd3, 1'b0);
        repeat (5) drive4(1'b1, 4'd4, 4'd4, 1'b0);
        idle4(7);
        // reset in the second CALC cycle, then Start on the release edge
        drive4(1'b1, 4'd7, 4'd7, 1'b0);
        drive4(1'b0, 4'd0, 4'd0, 1'b0);
        do_reset();
        drive4(1'b1, 4'd7, 4'd7, 1'b0);
        idle4(7);

        // randomized traffic with operands scrambled between Starts
        for (int i = 0; i < 400; i++)
            drive4(1'($urandom_range(0, 2) == 0), W'($urandom), W'($urandom), 1'($urandom));
        idle4(7);

        // wide instance: -128 * -1
        drive8(1'b1, 8'h80, 8'hFF, 1'b1);
        for (int i = 0; i < 10; i++) drive8(1'b0, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 120; i++)
            drive8(1'($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom), 1'($urandom));
        for (int i = 0; i < 12; i++) drive8(1'b0, 8'h00, 8'h00, 1'b0);

        chk("pending4", 64'(q4.size()), 64'd0);
        chk("pending8", 64'(q8.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
